// File: rtl/fft_unload.sv
// fft_unload: captures one FFT result frame and drains it to a valid/ready sink.
// Define FFT_UNLOAD_MAG_SQ_EN to drain re*re+im*im instead of the raw bin.
module fft_unload #(
   parameter int width = 16,
   parameter int N_2   = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               fft_start,
   input  logic               fft_done,
   input  logic [2*width-1:0] fft_wd,
   output logic [2*width-1:0] out_data,
   output logic [N_2-1:0]     out_bin,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_last,
   output logic               busy,
   output logic               overrun
);

   localparam int N  = 2**N_2;
   localparam int DW = 2*width;
   localparam logic [N_2-1:0] LASTB = N_2'(N-1);

   typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

   state_t state, state_nx;

   logic           done_q, done_rise;
   logic [N_2-1:0] cap_cnt, rd_cnt;
   logic           rd_done;
   logic [DW-1:0]  frame_buf [N];
   logic           wr_en;
   logic [N_2-1:0] wr_addr;

   logic           a_valid, a_last;
   logic [N_2-1:0] a_bin;
   logic [DW-1:0]  a_data;
   logic           a_adv, a_en, issue, hs;

   assign done_rise = fft_done & ~done_q;
   assign hs        = out_valid & out_ready;
   assign a_en      = ~a_valid | a_adv;
   assign issue     = (state == DRAIN) & ~rd_done & a_en;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (done_rise) state_nx = CAPTURE;
         CAPTURE: begin
            if (fft_start)             state_nx = IDLE;
            else if (cap_cnt == LASTB) state_nx = DRAIN;
         end
         DRAIN:   if (hs && out_last) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy    = (state != IDLE);
      wr_en   = ((state == IDLE) & done_rise) | (state == CAPTURE);
      wr_addr = (state == CAPTURE) ? cap_cnt : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         done_q  <= 1'b0;
         cap_cnt <= '0;
         rd_cnt  <= '0;
         rd_done <= 1'b0;
         overrun <= 1'b0;
      end else begin
         done_q <= fft_done;
         if (state == IDLE && done_rise) cap_cnt <= N_2'(1);
         else if (state == CAPTURE)      cap_cnt <= cap_cnt + 1'b1;
         if (state == CAPTURE) begin
            rd_cnt  <= '0;
            rd_done <= 1'b0;
         end else if (issue) begin
            rd_cnt  <= rd_cnt + 1'b1;
            rd_done <= (rd_cnt == LASTB);
         end
         if (state == DRAIN && done_rise) overrun <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) frame_buf[wr_addr] <= fft_wd;
   end

   // Read stage: holds its beat whenever the next stage cannot take it.
   always_ff @(posedge clk) begin
      if (reset) begin
         a_valid <= 1'b0;
         a_last  <= 1'b0;
         a_bin   <= '0;
         a_data  <= '0;
      end else if (a_en) begin
         a_valid <= issue;
         a_last  <= (rd_cnt == LASTB);
         a_bin   <= rd_cnt;
         a_data  <= frame_buf[rd_cnt];
      end
   end

`ifdef FFT_UNLOAD_MAG_SQ_EN
   logic              b_valid, b_last, b_en;
   logic [N_2-1:0]    b_bin;
   logic [DW-1:0]     b_data, mag;
   logic signed [DW-1:0] re_x, im_x;

   assign b_en  = ~b_valid | out_ready;
   assign a_adv = b_en;

   always_comb begin
      re_x = {{width{a_data[DW-1]}}, a_data[DW-1:width]};
      im_x = {{width{a_data[width-1]}}, a_data[width-1:0]};
      mag  = re_x * re_x + im_x * im_x;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         b_valid <= 1'b0;
         b_last  <= 1'b0;
         b_bin   <= '0;
         b_data  <= '0;
      end else if (b_en) begin
         b_valid <= a_valid;
         b_last  <= a_last;
         b_bin   <= a_bin;
         b_data  <= mag;
      end
   end

   assign out_valid = b_valid;
   assign out_last  = b_valid & b_last;
   assign out_bin   = b_bin;
   assign out_data  = b_data;
`else
   assign a_adv     = out_ready;
   assign out_valid = a_valid;
   assign out_last  = a_valid & a_last;
   assign out_bin   = a_bin;
   assign out_data  = a_data;
`endif

endmodule
